// File: rtl/cpu_cd_bus_arbiter_if.sv
// CD bus arbitration signals: requests, wait, buffer enables and completion strobes.
// The master modport is the requester/target side; the slave modport is the arbiter.
interface cpu_cd_bus_arbiter_if;
  logic REQ_STOC;
  logic REQ_DMA;
  logic REQ_MEM;
  logic CD_WAIT;
  logic STOC_n;
  logic DMA_OE_n;
  logic MEMRD_OE_n;
  logic ACK_STOC;
  logic ACK_DMA;
  logic ACK_MEM;
  logic CD_TMO;
  logic CD_BUSY;

  modport master (
    output REQ_STOC, REQ_DMA, REQ_MEM, CD_WAIT,
    input  STOC_n, DMA_OE_n, MEMRD_OE_n,
    input  ACK_STOC, ACK_DMA, ACK_MEM, CD_TMO, CD_BUSY
  );

  modport slave (
    input  REQ_STOC, REQ_DMA, REQ_MEM, CD_WAIT,
    output STOC_n, DMA_OE_n, MEMRD_OE_n,
    output ACK_STOC, ACK_DMA, ACK_MEM, CD_TMO, CD_BUSY
  );
endinterface

// File: rtl/cpu_cd_bus_arbiter.sv
// Arbiter and sequencer for the CPU data bus CD: fixed priority MEM > DMA > STOC with
// CPU-store starvation override, wait-state extension, timeout and turnaround gaps.
module cpu_cd_bus_arbiter #(
  parameter int XFER_CYC   = 1,
  parameter int TURN_CYC   = 0,
  parameter int STARVE_LIM = 3,
  parameter int WAIT_TMO   = 255
) (
  input logic sysclk,
  input logic sysrst_n,
  cpu_cd_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} arbStateT;
  typedef enum logic [1:0] {OWN_NONE, OWN_STOC, OWN_DMA, OWN_MEM} ownerT;

  localparam logic [3:0] XFER_LOAD  = 4'(XFER_CYC - 1);
  localparam logic [1:0] TURN_LOAD  = 2'(TURN_CYC - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(WAIT_TMO - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);
  localparam bit         HAS_TURN   = (TURN_CYC > 0);

  // Enable vector bit order: [2] MEM, [1] DMA, [0] STOC; active low, at most one bit low.
  localparam logic [2:0] EN_NONE = 3'b111;
  localparam logic [2:0] EN_STOC = 3'b110;
  localparam logic [2:0] EN_DMA  = 3'b101;
  localparam logic [2:0] EN_MEM  = 3'b011;

  arbStateT   stateQ, stateD;
  ownerT      ownerQ, ownerD;
  logic [2:0] enNQ, enND;
  logic [3:0] xferCntQ, xferCntD;
  logic [7:0] waitCntQ, waitCntD;
  logic [1:0] turnCntQ, turnCntD;
  logic [3:0] starveCntQ, starveCntD;
  logic       busyQ;

  logic anyReq;
  logic stocForced;
  logic xferDone;
  logic xferTmo;

  assign anyReq     = bus.REQ_STOC | bus.REQ_DMA | bus.REQ_MEM;
  assign stocForced = bus.REQ_STOC && (starveCntQ == STARVE_MAX);
  assign xferDone   = (stateQ == DRIVE) && !bus.CD_WAIT && (xferCntQ == 4'd0);
  assign xferTmo    = (stateQ == DRIVE) && bus.CD_WAIT && (waitCntQ == WAIT_LAST);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    stateD     = stateQ;
    ownerD     = ownerQ;
    enND       = enNQ;
    xferCntD   = xferCntQ;
    waitCntD   = waitCntQ;
    turnCntD   = turnCntQ;
    starveCntD = starveCntQ;

    unique case (stateQ)
      IDLE: begin
        if (anyReq) begin
          stateD   = DRIVE;
          xferCntD = XFER_LOAD;
          waitCntD = 8'd0;
          if (stocForced || (!bus.REQ_MEM && !bus.REQ_DMA)) begin
            ownerD     = OWN_STOC;
            enND       = EN_STOC;
            starveCntD = 4'd0;
          end else begin
            if (bus.REQ_MEM) begin
              ownerD = OWN_MEM;
              enND   = EN_MEM;
            end else begin
              ownerD = OWN_DMA;
              enND   = EN_DMA;
            end
            if (bus.REQ_STOC && (starveCntQ != STARVE_MAX)) starveCntD = starveCntQ + 4'd1;
          end
        end
      end

      DRIVE: begin
        if (xferDone || xferTmo) begin
          ownerD   = OWN_NONE;
          enND     = EN_NONE;
          waitCntD = 8'd0;
          if (HAS_TURN) begin
            stateD   = TURN;
            turnCntD = TURN_LOAD;
          end else begin
            stateD = IDLE;
          end
        end else if (bus.CD_WAIT) begin
          waitCntD = waitCntQ + 8'd1;
        end else begin
          // Not done and no wait implies xferCntQ is non-zero here.
          waitCntD = 8'd0;
          xferCntD = xferCntQ - 4'd1;
        end
      end

      TURN: begin
        if (turnCntQ == 2'd0) stateD = IDLE;
        else                  turnCntD = turnCntQ - 2'd1;
      end

      default: begin
        stateD = IDLE;
        ownerD = OWN_NONE;
        enND   = EN_NONE;
      end
    endcase

    if (!bus.REQ_STOC) starveCntD = 4'd0;
  end

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      stateQ     <= IDLE;
      ownerQ     <= OWN_NONE;
      enNQ       <= EN_NONE;
      xferCntQ   <= 4'd0;
      waitCntQ   <= 8'd0;
      turnCntQ   <= 2'd0;
      starveCntQ <= 4'd0;
      busyQ      <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      stateQ     <= stateD;
      ownerQ     <= ownerD;
      enNQ       <= enND;
      xferCntQ   <= xferCntD;
      waitCntQ   <= waitCntD;
      turnCntQ   <= turnCntD;
      starveCntQ <= starveCntD;
      busyQ      <= (stateD != IDLE);
    end
  end

  // Enables come straight from flops so the CD buffers never see decode glitches.
  assign bus.MEMRD_OE_n = enNQ[2];
  assign bus.DMA_OE_n   = enNQ[1];
  assign bus.STOC_n     = enNQ[0];

  assign bus.ACK_MEM  = xferDone && (ownerQ == OWN_MEM);
  assign bus.ACK_DMA  = xferDone && (ownerQ == OWN_DMA);
  assign bus.ACK_STOC = xferDone && (ownerQ == OWN_STOC);
  assign bus.CD_TMO   = xferTmo;
  assign bus.CD_BUSY  = busyQ;

endmodule

// File: tb/tb_cpu_cd_bus_arbiter.sv
// Directed bench for cpu_cd_bus_arbiter: unit A (XFER 1, TURN 0, WAIT_TMO 4) and
// unit B (XFER 2, TURN 1, WAIT_TMO 4), both with STARVE_LIM 3.
module tb_cpu_cd_bus_arbiter;

  logic sysclk = 1'b0;
  logic sysrst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 sysclk = ~sysclk;

  cpu_cd_bus_arbiter_if ia ();
  cpu_cd_bus_arbiter_if ib ();

  cpu_cd_bus_arbiter #(.XFER_CYC(1), .TURN_CYC(0), .STARVE_LIM(3), .WAIT_TMO(4)) u_a (
    .sysclk(sysclk), .sysrst_n(sysrst_n), .bus(ia)
  );

  cpu_cd_bus_arbiter #(.XFER_CYC(2), .TURN_CYC(1), .STARVE_LIM(3), .WAIT_TMO(4)) u_b (
    .sysclk(sysclk), .sysrst_n(sysrst_n), .bus(ib)
  );

  // Priority/gap sequence on unit B, all three requesting at cycle 0; order {MEM,DMA,STOC}.
  localparam logic [2:0] PR_EN [13] = '{3'b111, 3'b011, 3'b011, 3'b111, 3'b111, 3'b101, 3'b101,
                                        3'b111, 3'b111, 3'b110, 3'b110, 3'b111, 3'b111};
  localparam logic [2:0] PR_ACK[13] = '{3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b010,
                                        3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
  localparam logic       PR_BSY[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                                        1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic checkState(input bit onB, input string tag, input logic [2:0] en,
                            input logic [2:0] ack, input logic busy, input logic tmo);
    logic [2:0] obsEn, obsAck;
    logic       obsBusy, obsTmo;
    #1;
    if (onB) begin
      obsEn   = {ib.MEMRD_OE_n, ib.DMA_OE_n, ib.STOC_n};
      obsAck  = {ib.ACK_MEM, ib.ACK_DMA, ib.ACK_STOC};
      obsBusy = ib.CD_BUSY;
      obsTmo  = ib.CD_TMO;
    end else begin
      obsEn   = {ia.MEMRD_OE_n, ia.DMA_OE_n, ia.STOC_n};
      obsAck  = {ia.ACK_MEM, ia.ACK_DMA, ia.ACK_STOC};
      obsBusy = ia.CD_BUSY;
      obsTmo  = ia.CD_TMO;
    end
    check({tag, " en_n"}, {5'd0, obsEn},  {5'd0, en});
    check({tag, " ack"},  {5'd0, obsAck}, {5'd0, ack});
    check({tag, " busy"}, {7'd0, obsBusy}, {7'd0, busy});
    check({tag, " tmo"},  {7'd0, obsTmo},  {7'd0, tmo});
  endtask

  task automatic clearInputs();
    ia.REQ_STOC = 1'b0; ia.REQ_DMA = 1'b0; ia.REQ_MEM = 1'b0; ia.CD_WAIT = 1'b0;
    ib.REQ_STOC = 1'b0; ib.REQ_DMA = 1'b0; ib.REQ_MEM = 1'b0; ib.CD_WAIT = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] e3, a3;
    sysrst_n = 1'b0;
    clearInputs();

    // Reset held: requests toggling must not move anything.
    for (int i = 0; i < 3; i++) begin
      tick();
      ia.REQ_STOC = i[0];  ia.REQ_DMA = ~i[0]; ia.REQ_MEM = 1'b1; ia.CD_WAIT = 1'b1;
      ib.REQ_STOC = ~i[0]; ib.REQ_DMA = i[0];  ib.REQ_MEM = 1'b1; ib.CD_WAIT = 1'b1;
      checkState(1'b0, $sformatf("rst a %0d", i), 3'b111, 3'b000, 1'b0, 1'b0);
      checkState(1'b1, $sformatf("rst b %0d", i), 3'b111, 3'b000, 1'b0, 1'b0);
    end
    clearInputs();
    tick();
    sysrst_n = 1'b1;

    // Single STOC transfer on A: drive cycle 1 only, ACK in cycle 1, idle in cycle 2.
    tick(); ia.REQ_STOC = 1'b1;
    checkState(1'b0, "stoc c0", 3'b111, 3'b000, 1'b0, 1'b0);
    tick();
    checkState(1'b0, "stoc c1", 3'b110, 3'b001, 1'b1, 1'b0);
    ia.REQ_STOC = 1'b0;
    tick();
    checkState(1'b0, "stoc c2", 3'b111, 3'b000, 1'b0, 1'b0);

    // Priority and turnaround gap on B.
    for (int c = 0; c < 13; c++) begin
      tick();
      if (c == 0) begin
        ib.REQ_MEM = 1'b1; ib.REQ_DMA = 1'b1; ib.REQ_STOC = 1'b1;
      end
      checkState(1'b1, $sformatf("prio c%0d", c), PR_EN[c], PR_ACK[c], PR_BSY[c], 1'b0);
      if (PR_ACK[c][2]) ib.REQ_MEM  = 1'b0;
      if (PR_ACK[c][1]) ib.REQ_DMA  = 1'b0;
      if (PR_ACK[c][0]) ib.REQ_STOC = 1'b0;
    end

    // Starvation on A: MEM wins three times, STOC forced on the 4th arbitration, then repeat.
    for (int c = 0; c < 16; c++) begin
      tick();
      if (c == 0) begin
        ia.REQ_MEM = 1'b1; ia.REQ_DMA = 1'b1; ia.REQ_STOC = 1'b1;
      end
      if (c % 2 == 0) begin
        e3 = 3'b111; a3 = 3'b000;
      end else if (c == 7 || c == 15) begin
        e3 = 3'b110; a3 = 3'b001;
      end else begin
        e3 = 3'b011; a3 = 3'b100;
      end
      checkState(1'b0, $sformatf("starve c%0d", c), e3, a3, c[0], 1'b0);
    end
    clearInputs();
    tick();
    checkState(1'b0, "starve end", 3'b111, 3'b000, 1'b0, 1'b0);

    // Wait extension on B: three wait cycles starting in the first DRIVE cycle.
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) ib.REQ_DMA = 1'b1;
      ib.CD_WAIT = (c >= 1 && c <= 3);
      e3 = (c >= 1 && c <= 5) ? 3'b101 : 3'b111;
      a3 = (c == 5) ? 3'b010 : 3'b000;
      checkState(1'b1, $sformatf("wait c%0d", c), e3, a3, (c >= 1 && c <= 6), 1'b0);
      if (c == 5) ib.REQ_DMA = 1'b0;
    end
    ib.CD_WAIT = 1'b0;

    // Timeout on A: CD_WAIT stuck high, CD_TMO in the 4th DRIVE cycle, no ACK.
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 0) begin
        ia.REQ_MEM = 1'b1; ia.CD_WAIT = 1'b1;
      end
      e3 = (c >= 1 && c <= 4) ? 3'b011 : 3'b111;
      checkState(1'b0, $sformatf("tmo c%0d", c), e3, 3'b000, (c >= 1 && c <= 4), (c == 4));
      if (c == 4) ia.REQ_MEM = 1'b0;
    end
    ia.CD_WAIT = 1'b0;

    // Asynchronous reset in the middle of a DMA drive on B.
    tick(); ib.REQ_DMA = 1'b1;
    checkState(1'b1, "arst c0", 3'b111, 3'b000, 1'b0, 1'b0);
    tick();
    checkState(1'b1, "arst c1", 3'b101, 3'b000, 1'b1, 1'b0);
    sysrst_n = 1'b0;
    checkState(1'b1, "arst low", 3'b111, 3'b000, 1'b0, 1'b0);
    ib.REQ_DMA = 1'b0;
    tick();
    sysrst_n = 1'b1;
    tick();
    checkState(1'b1, "arst post", 3'b111, 3'b000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
